// File: rtl/pc_sequencer.sv
// MIPS fetch-stage program counter with next-PC selection, stall hold and a
// one-entry pending-redirect buffer for redirects that arrive while stalled.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = {{(WIDTH-8){1'b0}}, 8'h80}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       pc_src,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             redirect_pending,
  output logic             misalign,
  output logic [WIDTH-1:0] bad_addr
);

  localparam logic [1:0] SRC_SEQ = 2'b00;
  localparam logic [1:0] SRC_BR  = 2'b01;
  localparam logic [1:0] SRC_JMP = 2'b10;
  localparam logic [1:0] SRC_EXC = 2'b11;

  typedef struct packed {
    logic [WIDTH-1:0] target;
    logic             exc;
  } redir_t;

  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_e;

  buf_state_e       state, state_nx;
  redir_t           buf_q, buf_nx;
  redir_t           req;
  logic [WIDTH-1:0] pc_nx;
  logic [WIDTH-1:0] raw_target;
  logic             is_redir;
  logic             is_bj;
  logic             mis_now;

  assign pc_plus4         = pc + {{(WIDTH-3){1'b0}}, 3'd4};
  assign redirect_pending = (state == BUF_FULL);

  // Resolve the incoming request; a misaligned branch/jump becomes an exception.
  always_comb begin
    raw_target = EXC_VECTOR;
    case (pc_src)
      SRC_BR:  raw_target = branch_target;
      SRC_JMP: raw_target = jump_target;
      default: raw_target = EXC_VECTOR;
    endcase
    is_redir   = (pc_src != SRC_SEQ);
    is_bj      = (pc_src == SRC_BR) || (pc_src == SRC_JMP);
    mis_now    = is_bj && (raw_target[1:0] != 2'b00);
    req.target = mis_now ? EXC_VECTOR : raw_target;
    req.exc    = (pc_src == SRC_EXC) || mis_now;
  end

  always_comb begin
    state_nx = state;
    buf_nx   = buf_q;
    pc_nx    = pc;
    if (stall) begin
      // A buffered exception is never displaced by a plain branch/jump.
      if (is_redir) begin
        state_nx = BUF_FULL;
        if (state == BUF_EMPTY || !(buf_q.exc && !req.exc))
          buf_nx = req;
      end
    end else begin
      state_nx = BUF_EMPTY;
      buf_nx   = '0;
      if (state == BUF_EMPTY)
        pc_nx = is_redir ? req.target : pc_plus4;
      else if (!is_redir)
        pc_nx = buf_q.target;
      else if (req.exc || !buf_q.exc)
        pc_nx = req.target;
      else
        pc_nx = buf_q.target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BUF_EMPTY;
      buf_q    <= '0;
      pc       <= RESET_VECTOR;
      misalign <= 1'b0;
      bad_addr <= '0;
    end else begin
      state    <= state_nx;
      buf_q    <= buf_nx;
      pc       <= pc_nx;
      misalign <= mis_now;
      if (mis_now)
        bad_addr <= raw_target;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table followed by
// randomized traffic against a queue-based reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_plus4, bad_addr;
  logic        redirect_pending, misalign;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .pc_src           (pc_src),
    .branch_target    (branch_target),
    .jump_target      (jump_target),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .redirect_pending (redirect_pending),
    .misalign         (misalign),
    .bad_addr         (bad_addr)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic [1:0]  src;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] epc;
    logic        epend;
    logic        emis;
    logic [31:0] ebad;
  } vec_t;

  typedef struct {
    logic [31:0] t;
    logic        e;
  } pend_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic stl, logic [1:0] src, logic [31:0] bt,
                              logic [31:0] jt, logic [31:0] epc, logic epend,
                              logic emis, logic [31:0] ebad);
    vec_t v;
    v.rst = rst; v.stl = stl; v.src = src; v.bt = bt; v.jt = jt;
    v.epc = epc; v.epend = epend; v.emis = emis; v.ebad = ebad;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(int idx, logic [31:0] epc, logic epend, logic emis, logic [31:0] ebad);
    chk("pc", idx, pc, epc);
    chk("pc_plus4", idx, pc_plus4, epc + 32'd4);
    chk("redirect_pending", idx, {31'd0, redirect_pending}, {31'd0, epend});
    chk("misalign", idx, {31'd0, misalign}, {31'd0, emis});
    chk("bad_addr", idx, bad_addr, ebad);
  endtask

  task automatic drive(logic rst, logic stl, logic [1:0] src, logic [31:0] bt, logic [31:0] jt);
    reset = rst; stall = stl; pc_src = src; branch_target = bt; jump_target = jt;
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic [31:0] m_pc, m_bad;
  logic        m_mis;
  pend_t       m_q[$];

  task automatic model_step(logic rst, logic stl, logic [1:0] src, logic [31:0] bt, logic [31:0] jt);
    logic [31:0] tgt;
    logic        bad, exc;
    pend_t       r;
    if (rst) begin
      m_pc = 32'h0; m_q.delete(); m_mis = 1'b0; m_bad = 32'h0;
      return;
    end
    tgt = (src == 2'd1) ? bt : (src == 2'd2) ? jt : 32'h80;
    bad = (src == 2'd1 || src == 2'd2) && (tgt % 4 != 0);
    exc = (src == 2'd3) || bad;
    if (bad) m_bad = tgt;
    m_mis = bad;
    if (exc) tgt = 32'h80;
    r.t = tgt; r.e = exc;
    if (stl) begin
      if (src != 2'd0) begin
        if (m_q.size() == 0) m_q.push_back(r);
        else if (!(m_q[0].e && !exc)) m_q[0] = r;
      end
    end else begin
      if (m_q.size() == 0) m_pc = (src == 2'd0) ? m_pc + 32'd4 : tgt;
      else if (src == 2'd0) m_pc = m_q[0].t;
      else if (exc || !m_q[0].e) m_pc = tgt;
      else m_pc = m_q[0].t;
      m_q.delete();
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pc_src = 2'b00; branch_target = '0; jump_target = '0;

    // rst stl src bt jt | pc pend mis bad
    vecs.push_back(mk(1, 0, 2'd2, 0, 32'h40, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 2'd2, 0, 32'h40, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 0, 32'h4, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 0, 32'h8, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 0, 32'hC, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 0, 32'h10, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'd1, 32'h200, 0, 32'h200, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'd2, 0, 32'h1000, 32'h1000, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'd2, 0, 32'h20, 32'h20, 0, 0, 32'h0));
    // stalled branch held for three cycles
    vecs.push_back(mk(0, 1, 2'd1, 32'h300, 0, 32'h20, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 2'd0, 0, 0, 32'h20, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 2'd0, 0, 0, 32'h20, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 0, 32'h300, 0, 0, 32'h0));
    // buffered exception survives a later jump and beats the releasing branch
    vecs.push_back(mk(0, 1, 2'd3, 0, 0, 32'h300, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 2'd2, 0, 32'h500, 32'h300, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'd1, 32'h600, 0, 32'h80, 0, 0, 32'h0));
    // unstalled misaligned jump
    vecs.push_back(mk(0, 0, 2'd2, 0, 32'h102, 32'h80, 0, 1, 32'h102));
    vecs.push_back(mk(0, 0, 2'd0, 0, 0, 32'h84, 0, 0, 32'h102));
    // wrap
    vecs.push_back(mk(0, 0, 2'd2, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 32'h102));
    vecs.push_back(mk(0, 0, 2'd0, 0, 0, 32'h0, 0, 0, 32'h102));
    // reset mid-stall discards the buffered branch
    vecs.push_back(mk(0, 1, 2'd1, 32'h700, 0, 32'h0, 1, 0, 32'h102));
    vecs.push_back(mk(1, 1, 2'd0, 0, 0, 32'h0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 0, 32'h4, 0, 0, 32'h0));
    // misalign pulses at capture into the buffer
    vecs.push_back(mk(0, 1, 2'd1, 32'h203, 0, 32'h4, 1, 1, 32'h203));
    vecs.push_back(mk(0, 1, 2'd0, 0, 0, 32'h4, 1, 0, 32'h203));
    vecs.push_back(mk(0, 0, 2'd0, 0, 0, 32'h80, 0, 0, 32'h203));
    // newer stalled jump replaces a buffered branch
    vecs.push_back(mk(0, 1, 2'd1, 32'h400, 0, 32'h80, 1, 0, 32'h203));
    vecs.push_back(mk(0, 1, 2'd2, 0, 32'h800, 32'h80, 1, 0, 32'h203));
    vecs.push_back(mk(0, 0, 2'd0, 0, 0, 32'h800, 0, 0, 32'h203));
    // new unstalled jump beats a buffered branch
    vecs.push_back(mk(0, 1, 2'd1, 32'h400, 0, 32'h800, 1, 0, 32'h203));
    vecs.push_back(mk(0, 0, 2'd2, 0, 32'h900, 32'h900, 0, 0, 32'h203));
    // new exception beats a buffered branch; stalled exception then sequential release
    vecs.push_back(mk(0, 1, 2'd1, 32'h400, 0, 32'h900, 1, 0, 32'h203));
    vecs.push_back(mk(0, 0, 2'd3, 0, 0, 32'h80, 0, 0, 32'h203));
    vecs.push_back(mk(0, 1, 2'd3, 0, 0, 32'h80, 1, 0, 32'h203));
    vecs.push_back(mk(0, 0, 2'd0, 0, 0, 32'h80, 0, 0, 32'h203));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].src, vecs[i].bt, vecs[i].jt);
      check_all(i, vecs[i].epc, vecs[i].epend, vecs[i].emis, vecs[i].ebad);
    end

    // Randomized traffic; first cycle is a reset to sync the model.
    for (int n = 0; n < 2000; n++) begin
      logic        r, s;
      logic [1:0]  src;
      logic [31:0] bt, jt;
      r   = (n == 0) || ($urandom_range(0, 31) == 0);
      s   = $urandom_range(0, 1) == 1;
      src = 2'($urandom_range(0, 3));
      bt  = $urandom;
      jt  = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) jt[1:0] = 2'b00;
      model_step(r, s, src, bt, jt);
      drive(r, s, src, bt, jt);
      check_all(1000 + n, m_pc, m_q.size() != 0, m_mis, m_bad);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
